sc1602_text_buffer: RTL and testbench
=====================================

Name: sc1602_text_buffer

Overview:
- Upstream character/command source for sc1602_driver.
- Holds a ROWS x COLS text frame in sys_clk-domain RAM and presents one character at a time on char_out, advancing on each completed driver draw.
- Also queues one display command (window shift etc.) from host logic until the driver takes it.
- Driver status inputs (drawing, driver_ready) come from the sc1602_clk domain and are synchronised inside this block.

Parameters:
- COLS, 16, characters per line.
- ROWS, 2, display lines; DEPTH = ROWS*COLS; AW = $clog2(DEPTH).
- FILL_CHAR, 8'h20, value written by clear and by the post-reset fill.
- SYNC_STAGES, 2, flop stages on each async status input (minimum 2).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_addr  in  AW  host write address (row*COLS+col).
- wr_data  in  8  character code.
- clear  in  1  start a fill with FILL_CHAR.
- busy  out  1  fill in progress.
- drawing  in  1  driver draw-in-progress flag (async).
- char_out  out  8  character for the driver's character_in.
- char_index  out  AW  address currently presented.
- frame_done  out  1  one-cycle pulse on index wrap.
- cmd_valid  in  1  host command request.
- cmd  in  3  {2b command, 1b LR}.
- cmd_ready  out  1  holding register empty.
- driver_ready  in  1  driver ready_o (async).
- command_out  out  3  to the driver's command_in; 3'b000 = none.

Behaviour:
- Reset values (async assert):
  - char_index=0, char_out=FILL_CHAR, frame_done=0, command_out=0, cmd_ready=0, busy=1.
  - Sync chains clear to 0.
- Deassert release:
  - A fill starts automatically; RAM is never reset directly.
  - cmd_ready=1 from the first clock after release.
- Fill:
  - One address per cycle, 0..DEPTH-1; busy stays high for exactly DEPTH cycles, then drops.
  - While busy, wr_en is ignored and clear is ignored.
  - clear while idle starts the fill on the next cycle.
- Host write (wr_en, not busy):
  - mem[wr_addr] <= wr_data.
  - wr_addr >= DEPTH is dropped.
- char_out:
  - Registered from mem[char_index] and updated every cycle.
  - A write or fill to the presented address shows on char_out 2 cycles after the write strobe (write-through, no stale hold).
- Advance:
  - Trigger is a falling edge of synchronised drawing, detected with a 1-flop delay after the sync chain.
  - char_index increments; DEPTH-1 wraps to 0.
  - frame_done pulses 1 cycle in the same cycle the index becomes 0.
  - Advance continues during a fill.
- Command path:
  - Single-entry register. Accept on cmd_valid && cmd_ready: cmd_ready->0, command_out<=cmd next cycle.
  - cmd==3'b000 is accepted and discarded; cmd_ready stays 1.
  - Release: on a synchronised falling edge of driver_ready while pending, command_out->0 and cmd_ready->1 in the same cycle.
  - A falling edge with nothing pending has no effect.
  - cmd_valid in the release cycle is not accepted; cmd_ready is still 0 that cycle.
- Simultaneous events:
  - Advance and write at the same address: write wins in RAM, and char_out reflects the new index.
  - clear and wr_en in the same idle cycle: clear wins and the write is dropped.
- Reset mid-fill or mid-command: everything returns to reset values and the fill restarts from address 0.

Decomposition:
- Package sc1602_pkg holds:
  - Command encodings: CMD_NONE=3'b000, CMD_SHIFT_L=3'b010, CMD_SHIFT_R=3'b011.
  - FILL_CHAR default.
  - Function for row/col-to-address mapping.
- One sub-module: sc1602_sync_edge, an N-stage synchroniser plus fall-edge pulse. It is instanced twice, for drawing and driver_ready.

Test Plan:
- Reset release -> busy high for 32 cycles, then 0; char_out=8'h20 at every index over one frame of 32 drawing pulses.
- Write "FPGA" (46,50,47,41) to addr 1..4, then 5 drawing pulses -> char_out sequence 20,46,50,47,41; char_index 0->5.
- 32 drawing falls -> frame_done exactly one pulse, coincident with char_index=0; no pulse on the other 31.
- cmd=3'b010 with driver_ready=1 -> command_out=010, cmd_ready=0; a second cmd_valid is ignored; after driver_ready falls, command_out=0 and cmd_ready=1 within SYNC_STAGES+2 cycles.
- clear asserted together with wr_en addr 3 data 8'h41 -> addr 3 reads 8'h20 after busy drops; a write issued during busy has no effect.
- sys_rst pulsed at fill cycle 10 with pending command -> command_out=0, char_index=0, busy restarts a full 32-cycle fill.

Source files
------------

// File: rtl/sc1602_pkg.sv
// Shared definitions for the SC1602 text buffer: driver command codes, FSM states,
// the default fill character and row/column address mapping.
package sc1602_pkg;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'b000,
      CMD_SHIFT_L = 3'b010,
      CMD_SHIFT_R = 3'b011
   } cmd_e;

   typedef enum logic [1:0] {
      CMD_ST_INIT,
      CMD_ST_IDLE,
      CMD_ST_PEND
   } cmd_state_e;

   localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

   function automatic int rc_to_addr(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/sc1602_sync_edge.sv
// Multi-flop synchroniser for a signal from the display clock domain, followed by
// a one-flop delay that yields a single-cycle falling-edge pulse.
module sc1602_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic fall
);

   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] chain;
   logic         level_d;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain   <= '0;
         level_d <= 1'b0;
      end else begin
         chain   <= {chain[N-2:0], async_in};
         level_d <= chain[N-1];
      end
   end

   assign fall = level_d & ~chain[N-1];

endmodule

// File: rtl/sc1602_text_buffer.sv
// Text frame RAM, character sequencer and single-entry command register feeding
// the sc1602_driver; driver status is brought into sys_clk through sc1602_sync_edge.
module sc1602_text_buffer
   import sc1602_pkg::*;
#(
   parameter  int          COLS        = 16,
   parameter  int          ROWS        = 2,
   parameter  logic [7:0]  FILL_CHAR   = FILL_CHAR_DEFAULT,
   parameter  int          SYNC_STAGES = 2,
   localparam int          DEPTH       = ROWS * COLS,
   localparam int          AW          = $clog2(DEPTH)
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          clear,
   output logic          busy,
   input  logic          drawing,
   output logic [7:0]    char_out,
   output logic [AW-1:0] char_index,
   output logic          frame_done,
   input  logic          cmd_valid,
   input  logic [2:0]    cmd,
   output logic          cmd_ready,
   input  logic          driver_ready,
   output logic [2:0]    command_out
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] fill_addr;
   logic          draw_fall;
   logic          ready_fall;
   logic          host_wr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   cmd_state_e    cmd_state, cmd_state_nx;
   logic [2:0]    command_nx;

   sc1602_sync_edge #(.STAGES(SYNC_STAGES)) u_draw_sync (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .async_in (drawing),
      .fall     (draw_fall)
   );

   sc1602_sync_edge #(.STAGES(SYNC_STAGES)) u_ready_sync (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .async_in (driver_ready),
      .fall     (ready_fall)
   );

   // Fill sequencer: reset leaves busy high so the frame is blanked right after release.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         busy      <= 1'b1;
         fill_addr <= '0;
      end else if (busy) begin
         fill_addr <= fill_addr + AW'(1);
         if (fill_addr == AW'(DEPTH - 1)) busy <= 1'b0;
      end else if (clear) begin
         busy      <= 1'b1;
         fill_addr <= '0;
      end
   end

   // Clear has priority over a host write in the same cycle.
   assign host_wr   = wr_en && !busy && !clear && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
   assign mem_we    = busy || host_wr;
   assign mem_waddr = busy ? fill_addr : wr_addr;
   assign mem_wdata = busy ? FILL_CHAR : wr_data;

   // NOTE: the RAM has no reset; the post-reset fill initialises it instead.
   always_ff @(posedge sys_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         char_index <= '0;
         char_out   <= FILL_CHAR;
         frame_done <= 1'b0;
      end else begin
         char_out   <= mem[char_index];
         frame_done <= 1'b0;
         if (draw_fall) begin
            if (char_index == AW'(DEPTH - 1)) begin
               char_index <= '0;
               frame_done <= 1'b1;
            end else begin
               char_index <= char_index + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cmd_state   <= CMD_ST_INIT;
         command_out <= CMD_NONE;
      end else begin
         cmd_state   <= cmd_state_nx;
         command_out <= command_nx;
      end
   end

   // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
   always_comb begin
      cmd_state_nx = cmd_state;
      command_nx   = command_out;
      unique case (cmd_state)
         CMD_ST_INIT: cmd_state_nx = CMD_ST_IDLE;
         CMD_ST_IDLE: begin
            if (cmd_valid && (cmd != CMD_NONE)) begin
               cmd_state_nx = CMD_ST_PEND;
               command_nx   = cmd;
            end
         end
         CMD_ST_PEND: begin
            if (ready_fall) begin
               cmd_state_nx = CMD_ST_IDLE;
               command_nx   = CMD_NONE;
            end
         end
         default: cmd_state_nx = CMD_ST_INIT;
      endcase
   end

   assign cmd_ready = (cmd_state == CMD_ST_IDLE);

endmodule

// File: tb/tb_sc1602_text_buffer.sv
// Self-checking bench for sc1602_text_buffer: table-driven and hand-written sequences
// plus random writes/draws checked against an array model of the frame.
module tb_sc1602_text_buffer;
   import sc1602_pkg::*;

   localparam int COLS  = 16;
   localparam int ROWS  = 2;
   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = $clog2(DEPTH);
   localparam int NS    = 2;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          clear;
   logic          busy;
   logic          drawing;
   logic [7:0]    char_out;
   logic [AW-1:0] char_index;
   logic          frame_done;
   logic          cmd_valid;
   logic [2:0]    cmd;
   logic          cmd_ready;
   logic          driver_ready;
   logic [2:0]    command_out;

   sc1602_text_buffer #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'h20), .SYNC_STAGES(NS)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .clear        (clear),
      .busy         (busy),
      .drawing      (drawing),
      .char_out     (char_out),
      .char_index   (char_index),
      .frame_done   (frame_done),
      .cmd_valid    (cmd_valid),
      .cmd          (cmd),
      .cmd_ready    (cmd_ready),
      .driver_ready (driver_ready),
      .command_out  (command_out)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         fd_count = 0;
   logic [7:0] exp_mem [DEPTH];
   int         exp_idx  = 0;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic [AW-1:0] exp_index;
      logic [7:0]    exp_char;
   } fpga_vec_t;

   fpga_vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Frame-done pulses are counted here; each must coincide with index 0.
   always @(negedge sys_clk) begin
      if (frame_done === 1'b1) begin
         fd_count++;
         check("frame_done_at_index0", 32'(char_index), 32'd0);
      end
   end

   task automatic model_fill();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h20;
   endtask

   task automatic wait_fill(input string name, input int start);
      int cnt = start;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
      check(name, 32'(cnt), 32'(DEPTH));
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      if (int'(a) < DEPTH) exp_mem[a] = d;
   endtask

   // One drawing pulse; optionally writes the address being advanced to in the advance cycle.
   task automatic draw_pulse(input bit do_wr, input logic [7:0] wd);
      int fd0 = fd_count;
      int nxt = (exp_idx + 1) % DEPTH;
      drawing = 1'b1;
      repeat (NS + 1) tick();
      drawing = 1'b0;
      repeat (NS) tick();
      if (do_wr) begin
         wr_en = 1'b1; wr_addr = AW'(nxt); wr_data = wd;
      end
      tick();
      wr_en = 1'b0;
      tick();
      exp_idx = nxt;
      if (do_wr) exp_mem[nxt] = wd;
      check("advance_index", 32'(char_index), 32'(exp_idx));
      check("advance_char", 32'(char_out), 32'(exp_mem[exp_idx]));
      check("frame_done_count", 32'(fd_count - fd0), 32'(nxt == 0));
   endtask

   task automatic walk_frame();
      for (int i = 0; i < DEPTH; i++) draw_pulse(1'b0, 8'h00);
   endtask

   task automatic send_cmd(input logic [2:0] c);
      cmd_valid = 1'b1; cmd = c;
      tick();
      cmd_valid = 1'b0; cmd = 3'b000;
   endtask

   task automatic wait_release(input string name);
      int cnt = 0;
      while (!cmd_ready && cnt < 20) begin
         tick();
         cnt++;
      end
      check(name, 32'(cnt >= 1 && cnt <= NS + 2), 32'd1);
   endtask

   initial begin
      sys_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0;
      drawing = 1'b0; cmd_valid = 1'b0; cmd = 3'b000; driver_ready = 1'b1;

      vecs[0] = '{1'b0, AW'(0), 8'h00, AW'(0), 8'h20};
      vecs[1] = '{1'b1, AW'(rc_to_addr(0, 1, COLS)), 8'h46, AW'(1), 8'h46};
      vecs[2] = '{1'b1, AW'(rc_to_addr(0, 2, COLS)), 8'h50, AW'(2), 8'h50};
      vecs[3] = '{1'b1, AW'(rc_to_addr(0, 3, COLS)), 8'h47, AW'(3), 8'h47};
      vecs[4] = '{1'b1, AW'(rc_to_addr(0, 4, COLS)), 8'h41, AW'(4), 8'h41};
      vecs[5] = '{1'b0, AW'(0), 8'h00, AW'(5), 8'h20};

      // Reset state
      repeat (2) tick();
      check("rst_char_index", 32'(char_index), 32'd0);
      check("rst_char_out", 32'(char_out), 32'h20);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_command_out", 32'(command_out), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);

      // Release: cmd_ready on first clock, fill lasts DEPTH cycles
      sys_rst = 1'b0;
      tick();
      check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
      wait_fill("post_reset_fill_len", 1);
      model_fill();
      exp_idx = 0;
      tick();
      check("idle_char_index", 32'(char_index), 32'd0);
      check("idle_char_out", 32'(char_out), 32'h20);
      walk_frame();

      // "FPGA" at addresses 1..4, then step through the table
      foreach (vecs[i]) if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].data);
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i > 0) draw_pulse(1'b0, 8'h00);
         check("fpga_index", 32'(char_index), 32'(vecs[i].exp_index));
         check("fpga_char", 32'(char_out), 32'(vecs[i].exp_char));
      end

      // Command path
      send_cmd(CMD_SHIFT_L);
      check("cmd_accept_out", 32'(command_out), 32'(CMD_SHIFT_L));
      check("cmd_accept_ready", 32'(cmd_ready), 32'd0);
      send_cmd(CMD_SHIFT_R);
      check("cmd_second_ignored", 32'(command_out), 32'(CMD_SHIFT_L));
      driver_ready = 1'b0;
      wait_release("cmd_release_latency");
      check("cmd_release_out", 32'(command_out), 32'd0);
      driver_ready = 1'b1;
      repeat (NS + 2) tick();
      driver_ready = 1'b0;
      repeat (NS + 3) tick();
      check("fall_no_pending_ready", 32'(cmd_ready), 32'd1);
      check("fall_no_pending_out", 32'(command_out), 32'd0);
      driver_ready = 1'b1;
      repeat (NS + 2) tick();
      send_cmd(3'b000);
      check("cmd_none_ready", 32'(cmd_ready), 32'd1);
      check("cmd_none_out", 32'(command_out), 32'd0);

      // cmd_valid held through the release cycle is taken only on the next cycle
      send_cmd(CMD_SHIFT_R);
      cmd_valid = 1'b1; cmd = CMD_SHIFT_L;
      driver_ready = 1'b0;
      wait_release("cmd_release_latency2");
      check("release_cycle_not_accepted", 32'(command_out), 32'd0);
      tick();
      cmd_valid = 1'b0; cmd = 3'b000;
      check("accept_after_release", 32'(command_out), 32'(CMD_SHIFT_L));
      check("accept_after_release_ready", 32'(cmd_ready), 32'd0);
      driver_ready = 1'b1;
      repeat (NS + 2) tick();
      driver_ready = 1'b0;
      wait_release("cmd_release_latency3");
      driver_ready = 1'b1;
      repeat (NS + 2) tick();

      // clear wins over a simultaneous write; writes and clear during the fill are ignored
      clear = 1'b1; wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'h41;
      tick();
      clear = 1'b0; wr_en = 1'b0;
      check("clear_starts_fill", 32'(busy), 32'd1);
      begin
         int cnt = 0;
         while (busy && cnt < 100) begin
            if (cnt == 5) begin
               wr_en = 1'b1; wr_addr = AW'(2); wr_data = 8'h55;
            end else if (cnt == 8) begin
               clear = 1'b1;
            end
            tick();
            wr_en = 1'b0; clear = 1'b0;
            cnt++;
         end
         check("clear_fill_len", 32'(cnt), 32'(DEPTH));
      end
      model_fill();
      tick();
      walk_frame();

      // Random writes, write-through checks and draws against the model
      for (int it = 0; it < 80; it++) begin
         int         op = int'($urandom_range(0, 3));
         logic [7:0] d  = 8'($urandom);
         case (op)
            0: host_write(AW'($urandom_range(0, DEPTH - 1)), d);
            1: begin
               host_write(AW'(exp_idx), d);
               tick();
               check("write_through", 32'(char_out), 32'(d));
            end
            2: draw_pulse(1'b0, 8'h00);
            default: draw_pulse(1'b1, d);
         endcase
      end

      // Reset in the middle of a fill with a command pending
      send_cmd(CMD_SHIFT_R);
      check("pend_before_reset", 32'(command_out), 32'(CMD_SHIFT_R));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (10) tick();
      sys_rst = 1'b1;
      #1;
      check("midrst_command_out", 32'(command_out), 32'd0);
      check("midrst_char_index", 32'(char_index), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      sys_rst = 1'b0;
      tick();
      check("midrst_cmd_ready_release", 32'(cmd_ready), 32'd1);
      wait_fill("midrst_fill_len", 1);
      model_fill();
      exp_idx = 0;
      tick();
      walk_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
